// File: rtl/cordic_angle_sweep_pkg.sv
// Shared definitions for the cordic angle sweep front end.
// Holds the angle constants at 28 fractional bits, a helper that rescales
// them to another fractional width, and the sweep FSM state type.
package cordic_angle_sweep_pkg;

    // Exact integer angle constants at FPSHIFT = 28.
    localparam longint HALF_PI_Q28       = 64'sd421657428;
    localparam longint PI_Q28            = 64'sd843314857;
    localparam longint THREE_HALF_PI_Q28 = 64'sd1264972285;
    localparam longint TWO_PI_Q28        = 64'sd1686629713;

    // Rescale a Q.28 constant to a different number of fractional bits.
    // At fpshift == 28 the value passes through unchanged.
    function automatic longint scale_q28(input longint q28, input int fpshift);
        if (fpshift >= 28)
            return q28 <<< (fpshift - 28);
        else
            return q28 >>> (28 - fpshift);
    endfunction

    typedef enum logic [1:0] {
        ST_WAIT_TICK = 2'd0,
        ST_REDUCE    = 2'd1,
        ST_PRESENT   = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/cordic_angle_sweep_tick.sv
// tick_divider: free-running modulo-DIV counter with enable and sync clear.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active-low
//   en     in  count enable; low freezes the count
//   clr    in  synchronous clear, wins over en
//   tick   out high for the enabled cycle in which the count is DIV-1
module tick_divider #(
    parameter int DIV = 1200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cordic_angle_sweep.sv
// cordic_angle_sweep: rate-controlled phase sweep over [0, 2*pi) feeding the
// cordic core. Each phase is folded into [-pi/2, +pi/2] and offered on a
// valid/ready handshake; 'negate' tells the core to flip both cos and sin.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low
//   enable     in   sweep runs while high; low freezes the tick counter
//   restart    in   sync pulse: phase and tick back to 0, pending sample dropped
//   out_ready  in   downstream accepts the offered sample
//   out_valid  out  angle_out/negate/phase_out are valid
//   angle_out  out  reduced angle, signed, in [-pi/2, +pi/2]
//   negate     out  downstream must negate cos and sin
//   phase_out  out  unreduced phase in [0, 2*pi)
module cordic_angle_sweep
    import cordic_angle_sweep_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               FPSHIFT  = 28,
    parameter logic [WIDTH-1:0] STEP     = 4685082,
    parameter int               TICK_DIV = 1200000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    restart,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] angle_out,
    output logic                    negate,
    output logic        [WIDTH-1:0] phase_out
);

    localparam logic [WIDTH-1:0] HALF_PI_W       = WIDTH'(scale_q28(HALF_PI_Q28, FPSHIFT));
    localparam logic [WIDTH-1:0] PI_W            = WIDTH'(scale_q28(PI_Q28, FPSHIFT));
    localparam logic [WIDTH-1:0] THREE_HALF_PI_W = WIDTH'(scale_q28(THREE_HALF_PI_Q28, FPSHIFT));
    localparam logic [WIDTH-1:0] TWO_PI_W        = WIDTH'(scale_q28(TWO_PI_Q28, FPSHIFT));

    typedef struct packed {
        logic                    neg;
        logic signed [WIDTH-1:0] ang;
    } red_t;

    // Fold a phase in [0, 2*pi) into the core's convergence range.
    // The middle half-turn is shifted by pi and flagged for negation.
    function automatic red_t reduce(input logic [WIDTH-1:0] p);
        red_t r;
        if (p <= HALF_PI_W) begin
            r.ang = signed'(p);
            r.neg = 1'b0;
        end else if (p <= THREE_HALF_PI_W) begin
            r.ang = signed'(p - PI_W);
            r.neg = 1'b1;
        end else begin
            r.ang = signed'(p - TWO_PI_W);
            r.neg = 1'b0;
        end
        return r;
    endfunction

    // Phase step with wrap; the extra bit keeps the sum from overflowing
    // before the compare against 2*pi.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] p);
        logic [WIDTH:0] sum;
        sum = {1'b0, p} + {1'b0, STEP};
        if (sum >= {1'b0, TWO_PI_W})
            sum = sum - {1'b0, TWO_PI_W};
        return sum[WIDTH-1:0];
    endfunction

    sweep_state_t     state, state_nxt;
    logic [WIDTH-1:0] phase;
    logic             tick;
    logic             hs;
    red_t             red_p0;

    assign hs     = out_valid && out_ready;
    assign red_p0 = reduce(phase);

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable && (state == ST_WAIT_TICK)),
        .clr   (restart),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_WAIT_TICK;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_TICK: if (tick) state_nxt = ST_REDUCE;
            ST_REDUCE:    state_nxt = ST_PRESENT;
            ST_PRESENT:   if (hs) state_nxt = ST_WAIT_TICK;
            default:      state_nxt = ST_WAIT_TICK;
        endcase
        // restart beats a coincident handshake: the sample is not consumed
        if (restart)
            state_nxt = ST_WAIT_TICK;
    end

    // Stage p0 -> output register: reduction result captured in REDUCE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            out_valid <= 1'b0;
            angle_out <= '0;
            negate    <= 1'b0;
            phase_out <= '0;
        end else if (restart) begin
            phase     <= '0;
            out_valid <= 1'b0;
        end else if (state == ST_REDUCE) begin
            angle_out <= red_p0.ang;
            negate    <= red_p0.neg;
            phase_out <= phase;
            out_valid <= 1'b1;
        end else if (state == ST_PRESENT && hs) begin
            out_valid <= 1'b0;
            phase     <= advance(phase);
        end
    end

endmodule

// File: tb/tb_cordic_angle_sweep.sv
module tb_cordic_angle_sweep;

    localparam int     WIDTH    = 32;
    localparam int     FPSHIFT  = 28;
    localparam int     TICK_DIV = 4;
    localparam longint STEP     = 4685082;
    localparam longint HALF     = 421657428;
    localparam longint PI_C     = 843314857;
    localparam longint THREE    = 1264972285;
    localparam longint TWO      = 1686629713;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic restart = 1'b0;
    logic out_ready = 1'b0;
    logic out_valid;
    logic negate;
    logic signed [WIDTH-1:0] angle_out;
    logic [WIDTH-1:0] phase_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cordic_angle_sweep #(
        .WIDTH    (WIDTH),
        .FPSHIFT  (FPSHIFT),
        .STEP     (32'(STEP)),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .restart   (restart),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .angle_out (angle_out),
        .negate    (negate),
        .phase_out (phase_out)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference reduction straight from the angle-range rules.
    function automatic longint model_angle(input longint p);
        if (p <= HALF)       return p;
        else if (p <= THREE) return p - PI_C;
        else                 return p - TWO;
    endfunction

    function automatic longint model_neg(input longint p);
        return (p > HALF && p <= THREE) ? 1 : 0;
    endfunction

    // Hand-computed expectations for particular sample numbers since restart.
    task automatic pin(input longint k);
        case (k)
            0:   check("pin0_angle", angle_out, 0);
            1:   check("pin1_angle", angle_out, 4685082);
            2:   check("pin2_angle", angle_out, 9370164);
            90:  begin check("pin90_angle", angle_out, 421657380);  check("pin90_neg", negate, 0); end
            91:  begin check("pin91_angle", angle_out, -416972395); check("pin91_neg", negate, 1); end
            270: begin check("pin270_angle", angle_out, 421657283); check("pin270_neg", negate, 1); end
            271: begin check("pin271_angle", angle_out, -416972491); check("pin271_neg", negate, 0); end
            360: check("pin360_angle", angle_out, -193);
            361: check("pin361_phase", phase_out, 4684889);
            default: ;
        endcase
    endtask

    // Behavioural model: sample k since restart has phase (k*STEP) mod 2*pi;
    // a new sample appears one cycle after TICK_DIV enabled idle cycles.
    longint m_k = 0;
    int     m_cnt = 0;
    bit     m_valid = 1'b0;
    bit     m_red = 1'b0;
    longint ep;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_k = 0; m_cnt = 0; m_valid = 1'b0; m_red = 1'b0;
        end else begin
            check("out_valid", out_valid, m_valid);
            if (m_valid && out_valid) begin
                ep = (m_k * STEP) % TWO;
                check("phase_out", phase_out, ep);
                check("angle_out", angle_out, model_angle(ep));
                check("negate", negate, model_neg(ep));
                if (angle_out > HALF || angle_out < -HALF)
                    check("angle_range", angle_out, HALF);
                if (out_ready && !restart)
                    pin(m_k);
            end
            if (restart) begin
                m_k = 0; m_cnt = 0; m_valid = 1'b0; m_red = 1'b0;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_k++;
                end
            end else if (m_red) begin
                m_red = 1'b0;
                m_valid = 1'b1;
            end else if (enable) begin
                m_cnt++;
                if (m_cnt == TICK_DIV) begin
                    m_cnt = 0;
                    m_red = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!out_valid && n < budget) begin
            cyc();
            n++;
        end
        if (!out_valid)
            check(name, out_valid, 1);
    endtask

    longint hold_phase;
    longint hold_angle;
    int     first;

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_valid", out_valid, 0);
        check("rst_angle", angle_out, 0);
        check("rst_negate", negate, 0);
        check("rst_phase", phase_out, 0);

        // First sample latency after reset release
        enable = 1'b1;
        out_ready = 1'b1;
        rst_n = 1'b1;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (out_valid && first == 0) first = c;
        end
        check("first_valid_latency", first, 5);

        // Long sweep through a full turn with random stalls
        for (int n = 0; n < 8000 && m_k < 365; n++) begin
            cyc();
            enable = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        if (m_k < 365)
            check("sweep_timeout", m_k, 365);

        // Consumer stall holds the sample
        enable = 1'b1;
        out_ready = 1'b0;
        wait_valid(50, "stall_wait");
        hold_phase = phase_out;
        hold_angle = angle_out;
        repeat (50) cyc();
        check("stall_valid", out_valid, 1);
        check("stall_phase", phase_out, hold_phase);
        check("stall_angle", angle_out, hold_angle);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("single_handshake", out_valid, 0);
        wait_valid(50, "after_stall_wait");
        check("after_stall_phase", phase_out, (hold_phase + STEP) % TWO);

        // restart coincident with handshake
        out_ready = 1'b1;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("restart_valid", out_valid, 0);
        wait_valid(50, "restart_wait");
        check("restart_phase", phase_out, 0);

        // Tick counter freezes while enable is low
        cyc();
        cyc();
        cyc();
        enable = 1'b0;
        repeat (100) cyc();
        check("freeze_valid", out_valid, 0);
        enable = 1'b1;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (out_valid && first == 0) first = c;
        end
        check("resume_latency", first, 3);

        // Random traffic with occasional restarts
        for (int n = 0; n < 1500; n++) begin
            cyc();
            enable = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            restart = ($urandom_range(0, 99) == 0);
        end
        restart = 1'b0;

        // Asynchronous reset in the middle of a presented sample
        enable = 1'b1;
        out_ready = 1'b0;
        wait_valid(50, "reset_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_angle", angle_out, 0);
        check("midrst_negate", negate, 0);
        check("midrst_phase", phase_out, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (100) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
